// File: rtl/tiger_memslave_pkg.sv
// Shared constants and types for the Avalon-MM memory slave responder.
package tiger_memslave_pkg;

    localparam logic [15:0] MEMSLAVE_LFSR_SEED = 16'hACE1;
    localparam int unsigned MEMSLAVE_MAX_LAT   = 8;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } memslave_stage_t;

endpackage

// File: rtl/tiger_memslave_ram.sv
// Single-port, byte-enabled RAM with a registered (synchronous) read port.
module tiger_memslave_ram #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/tiger_avalon_mem_slave.sv
// Avalon-MM slave over on-chip RAM with fixed read latency and bounded outstanding reads.
// Optional wait-state injection: define TIGER_MEMSLAVE_WAIT_INJECT_EN.
module tiger_avalon_mem_slave
    import tiger_memslave_pkg::*;
#(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MAX_PENDING  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        avs_memSlave_read,
    input  logic        avs_memSlave_write,
    input  logic [31:0] avs_memSlave_address,
    input  logic [31:0] avs_memSlave_writedata,
    input  logic [3:0]  avs_memSlave_byteenable,
    output logic [31:0] avs_memSlave_readdata,
    output logic        avs_memSlave_waitrequest,
    output logic        avs_memSlave_readdatavalid,
    output logic        proto_err,
    output logic [3:0]  pending
);

    localparam logic [3:0] MaxPend = 4'(MAX_PENDING);

    logic            inject_stall;
    logic            read_acc;
    logic            write_acc;
    logic            acc_q;
    logic [31:0]     ram_rdata;
    logic [3:0]      pend_eff;
    logic [3:0]      pending_q;
    logic [3:0]      pending_d;
    logic            proto_err_q;
    memslave_stage_t head;
    memslave_stage_t last;
    logic            unused_addr;

    assign unused_addr = ^{avs_memSlave_address[31:ADDR_W+2], avs_memSlave_address[1:0]};

`ifdef TIGER_MEMSLAVE_WAIT_INJECT_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr_q <= MEMSLAVE_LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end

    assign inject_stall = lfsr_q[0] & lfsr_q[3];
`else
    assign inject_stall = 1'b0;
`endif

    // Throttle uses a zero count while in reset so waitrequest is defined before the first edge.
    assign pend_eff = reset_n ? pending_q : 4'd0;
    assign avs_memSlave_waitrequest = (avs_memSlave_read && (pend_eff == MaxPend)) || inject_stall;

    // A simultaneous read is dropped in favour of the write.
    assign write_acc = reset_n && avs_memSlave_write && !avs_memSlave_waitrequest;
    assign read_acc  = reset_n && avs_memSlave_read && !avs_memSlave_write &&
                       !avs_memSlave_waitrequest;

    tiger_memslave_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (write_acc),
        .be    (avs_memSlave_byteenable),
        .addr  (avs_memSlave_address[ADDR_W+1:2]),
        .wdata (avs_memSlave_writedata),
        .rdata (ram_rdata)
    );

    always_comb begin
        head.valid = acc_q;
        head.data  = ram_rdata;
    end

    if (READ_LATENCY == 1) begin : g_no_delay
        assign last = head;
    end else begin : g_delay
        memslave_stage_t line_q [READ_LATENCY-1];

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                for (int i = 0; i < int'(READ_LATENCY) - 1; i++) begin
                    line_q[i] <= '0;
                end
            end else begin
                line_q[0] <= head;
                for (int i = 1; i < int'(READ_LATENCY) - 1; i++) begin
                    line_q[i] <= line_q[i-1];
                end
            end
        end

        assign last = line_q[READ_LATENCY-2];
    end

    assign avs_memSlave_readdatavalid = last.valid;
    assign avs_memSlave_readdata      = last.valid ? last.data : 32'd0;

    always_comb begin
        pending_d = pending_q;
        if (read_acc && !last.valid) begin
            pending_d = pending_q + 4'd1;
        end else if (!read_acc && last.valid && (pending_q != 4'd0)) begin
            pending_d = pending_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q       <= 1'b0;
            pending_q   <= 4'd0;
            proto_err_q <= 1'b0;
        end else begin
            acc_q     <= read_acc;
            pending_q <= pending_d;
            if (avs_memSlave_read && avs_memSlave_write) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign pending   = pending_q;
    assign proto_err = proto_err_q;

endmodule
